pr_timer: RTL and testbench

PR_TIMER -- requirements
Module: pr_timer

---
 rtl/pr_timer_pkg.sv | 57 +++++
 rtl/tc_down_counter.sv | 32 +++
 rtl/pr_timer.sv | 123 ++++++++++++
 tb/tb_pr_timer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pr_timer_pkg.sv
// Shared definitions for the programmable timer: register offsets, CTRL layout,
// mode codes and FSM state encoding.
package pr_timer_pkg;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PRESET = 2'd1;
   localparam logic [1:0] ADDR_COUNT  = 2'd2;
   localparam logic [1:0] ADDR_RSVD   = 2'd3;

   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_MODE_LSB = 1;
   localparam int CTRL_MODE_MSB = 2;
   localparam int CTRL_IM_BIT   = 3;

   localparam logic [1:0] MODE_ONESHOT = 2'd0;
   localparam logic [1:0] MODE_RELOAD  = 2'd1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_CNT  = 2'd2;
   localparam logic [1:0] ST_INT  = 2'd3;

   typedef struct packed {
      logic       im;
      logic [1:0] mode;
      logic       en;
   } ctrl_t;

   function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
      logic [31:0] w;
      w = 32'd0;
      w[CTRL_EN_BIT]                 = c.en;
      w[CTRL_MODE_MSB:CTRL_MODE_LSB] = c.mode;
      w[CTRL_IM_BIT]                 = c.im;
      return w;
   endfunction

   function automatic ctrl_t word_to_ctrl(input logic [31:0] w);
      ctrl_t c;
      c.en   = w[CTRL_EN_BIT];
      c.mode = w[CTRL_MODE_MSB:CTRL_MODE_LSB];
      c.im   = w[CTRL_IM_BIT];
      return c;
   endfunction

   // Modes 2 and 3 are treated as one-shot.
   function automatic logic mode_is_reload(input logic [1:0] mode);
      logic r;
      case (mode)
         MODE_RELOAD:  r = 1'b1;
         MODE_ONESHOT: r = 1'b0;
         default:      r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/tc_down_counter.sv
// Loadable down counter with a zero flag; saturates at zero instead of wrapping.
module tc_down_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         zero
);

   logic [W-1:0] count_r;

   // Count register: load has priority over decrement.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= {W{1'b0}};
      end else if (load) begin
         count_r <= load_val;
      end else if (dec && (count_r != {W{1'b0}})) begin
         count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;
   assign zero  = (count_r == {W{1'b0}});

endmodule

// File: rtl/pr_timer.sv
// Bus-attached programmable timer: CTRL/PRESET/COUNT registers, one-shot and
// auto-reload modes, maskable interrupt.
module pr_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  Addr,
   input  logic        WE,
   input  logic [31:0] DIN,
   output logic [31:0] DOUT,
   output logic        IRQ
);
   import pr_timer_pkg::*;

   ctrl_t       ctrl_r;
   logic [31:0] preset_r;
   logic [1:0]  state_r;
   logic        pending_r;

   logic [1:0]  state_nxt_s;
   logic        load_s;
   logic        dec_s;
   logic [31:0] count_s;
   logic        zero_s;
   logic        last_s;
   logic        ctrl_we_s;
   logic        preset_we_s;

   assign ctrl_we_s   = WE && (Addr == ADDR_CTRL);
   assign preset_we_s = WE && (Addr == ADDR_PRESET);
   assign last_s      = zero_s || (count_s == 32'd1);

   tc_down_counter #(.W(32)) u_cnt (
      .clk      (clk),
      .rst_n    (rst),
      .load     (load_s),
      .load_val (preset_r),
      .dec      (dec_s),
      .count    (count_s),
      .zero     (zero_s)
   );

   // Next-state and counter control, all from pre-edge register values.
   always_comb begin
      state_nxt_s = state_r;
      load_s      = 1'b0;
      dec_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (ctrl_r.en) state_nxt_s = ST_LOAD;
            else           state_nxt_s = ST_IDLE;
         end
         ST_LOAD: begin
            load_s = 1'b1;
            if (preset_r == 32'd0) state_nxt_s = ST_INT;
            else                   state_nxt_s = ST_CNT;
         end
         ST_CNT: begin
            if (!ctrl_r.en) begin
               state_nxt_s = ST_IDLE;
            end else begin
               dec_s = 1'b1;
               if (last_s) state_nxt_s = ST_INT;
               else        state_nxt_s = ST_CNT;
            end
         end
         ST_INT: begin
            if (mode_is_reload(ctrl_r.mode)) state_nxt_s = ST_LOAD;
            else                             state_nxt_s = ST_IDLE;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_r <= ST_IDLE;
      else      state_r <= state_nxt_s;
   end

   // CTRL: a bus write beats the one-shot auto-clear of Enable.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl_r <= '{im: 1'b0, mode: 2'd0, en: 1'b0};
      end else if (ctrl_we_s) begin
         ctrl_r <= word_to_ctrl(DIN);
      end else if ((state_r == ST_INT) && !mode_is_reload(ctrl_r.mode)) begin
         ctrl_r.en <= 1'b0;
      end else begin
         ctrl_r <= ctrl_r;
      end
   end

   // PRESET only feeds the counter at LOAD, so mid-count writes wait.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)             preset_r <= 32'd0;
      else if (preset_we_s) preset_r <= DIN;
      else                  preset_r <= preset_r;
   end

   // Pending: set in INT; auto-reload pulses end at the following LOAD.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                      pending_r <= 1'b0;
      else if (ctrl_we_s)            pending_r <= 1'b0;
      else if (state_r == ST_INT)    pending_r <= 1'b1;
      else if (state_r == ST_LOAD)   pending_r <= 1'b0;
      else                           pending_r <= pending_r;
   end

   // Zero-latency read mux.
   always_comb begin
      DOUT = 32'd0;
      case (Addr)
         ADDR_CTRL:   DOUT = ctrl_to_word(ctrl_r);
         ADDR_PRESET: DOUT = preset_r;
         ADDR_COUNT:  DOUT = count_s;
         ADDR_RSVD:   DOUT = 32'd0;
         default:     DOUT = 32'd0;
      endcase
   end

   assign IRQ = pending_r & ctrl_r.im;

endmodule

// File: tb/tb_pr_timer.sv
// Scoreboard bench for pr_timer: stimulus queues expected DOUT/IRQ, a negedge
// monitor pops and compares.
module tb_pr_timer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  Addr = 2'd0;
   logic        WE = 1'b0;
   logic [31:0] DIN = 32'd0;
   logic [31:0] DOUT;
   logic        IRQ;

   typedef struct {
      string       name;
      logic [31:0] dout;
      logic        irq;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   pr_timer dut (
      .clk  (clk),
      .rst  (rst),
      .Addr (Addr),
      .WE   (WE),
      .DIN  (DIN),
      .DOUT (DOUT),
      .IRQ  (IRQ)
   );

   always @(negedge clk) begin
      while (sb.size() > 0) begin
         mon_e = sb.pop_front();
         vectors++;
         if (DOUT !== mon_e.dout || IRQ !== mon_e.irq) begin
            miscompares++;
            $display("FAIL %s: got DOUT=%h IRQ=%b, expected DOUT=%h IRQ=%b",
                     mon_e.name, DOUT, IRQ, mon_e.dout, mon_e.irq);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [1:0] a,
                      input logic [31:0] d, input logic i);
      exp_t e;
      Addr = a;
      e.name = name;
      e.dout = d;
      e.irq  = i;
      sb.push_back(e);
   endtask

   // Write lands on the next rising edge; returns 1 time unit after it.
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      #1;
      Addr = a;
      DIN  = d;
      WE   = 1'b1;
      @(posedge clk);
      #1;
      WE   = 1'b0;
   endtask

   initial begin
      logic [31:0] expc;
      logic        expi;
      int          p;

      tick();
      chk("reset_ctrl", 2'd0, 32'd0, 1'b0);
      tick();
      rst = 1'b1;

      // Reset mid-count with COUNT=3
      wr(2'd1, 32'd10);
      wr(2'd0, 32'h1);
      repeat (9) tick();
      chk("pre_reset_count3", 2'd2, 32'd3, 1'b0);
      tick();
      rst = 1'b0;
      for (int a = 0; a < 4; a++) begin
         chk("in_reset_dout", 2'(a), 32'd0, 1'b0);
         tick();
      end
      rst = 1'b1;
      wr(2'd1, 32'h1234);
      chk("preset_readback", 2'd1, 32'h1234, 1'b0);
      tick();
      chk("addr3_reads0", 2'd3, 32'd0, 1'b0);
      wr(2'd2, 32'h55);
      chk("count_write_ignored", 2'd2, 32'd0, 1'b0);
      wr(2'd3, 32'hFFFF_FFFF);
      chk("addr3_write_ignored", 2'd3, 32'd0, 1'b0);
      wr(2'd0, 32'hFFFF_FFF0);
      chk("ctrl_upper_bits_0", 2'd0, 32'd0, 1'b0);

      // Mode 0 countdown
      wr(2'd1, 32'd5);
      wr(2'd0, 32'h9);
      tick();
      tick();
      for (int i = 0; i < 6; i++) begin
         chk("m0_count", 2'd2, 32'(5 - i), 1'b0);
         tick();
      end
      chk("m0_irq_edge8_en0", 2'd0, 32'h8, 1'b1);
      tick();
      tick();
      chk("m0_irq_holds", 2'd2, 32'd0, 1'b1);
      wr(2'd0, 32'h8);
      chk("m0_ctrl_write_clears", 2'd0, 32'h8, 1'b0);

      // Mode 1 auto-reload, PRESET=3: period 5
      wr(2'd1, 32'd3);
      wr(2'd0, 32'hB);
      for (int k = 1; k <= 21; k++) begin
         tick();
         p = (k - 2) % 5;
         if (k < 2)       expc = 32'd0;
         else if (p <= 3) expc = 32'(3 - p);
         else             expc = 32'd0;
         expi = (k >= 6) && (((k - 6) % 5) == 0);
         chk("m1_reload", 2'd2, expc, expi);
      end
      wr(2'd0, 32'h0);
      chk("m1_disable", 2'd0, 32'd0, 1'b0);

      // PRESET=0, masked and unmasked
      wr(2'd1, 32'd0);
      wr(2'd0, 32'h9);
      tick();
      chk("p0_ctrl", 2'd0, 32'h9, 1'b0);
      tick();
      chk("p0_count", 2'd2, 32'd0, 1'b0);
      tick();
      chk("p0_irq_edge3", 2'd0, 32'h8, 1'b1);
      wr(2'd0, 32'h1);
      tick();
      tick();
      tick();
      chk("p0_masked_en_cleared", 2'd0, 32'd0, 1'b0);
      tick();
      chk("p0_masked_count", 2'd2, 32'd0, 1'b0);

      // Disable mid-count, then PRESET update during CNT
      wr(2'd1, 32'd10);
      wr(2'd0, 32'h9);
      repeat (9) tick();
      chk("dis_count3", 2'd2, 32'd3, 1'b0);
      wr(2'd0, 32'h0);
      chk("dis_count2", 2'd2, 32'd2, 1'b0);
      tick();
      chk("dis_hold_a", 2'd2, 32'd2, 1'b0);
      tick();
      tick();
      chk("dis_hold_b", 2'd2, 32'd2, 1'b0);
      wr(2'd0, 32'h3);
      tick();
      tick();
      tick();
      chk("upd_count9", 2'd2, 32'd9, 1'b0);
      wr(2'd1, 32'd7);
      chk("upd_count_unaffected", 2'd2, 32'd8, 1'b0);
      repeat (9) tick();
      chk("upd_int_count0", 2'd2, 32'd0, 1'b0);
      tick();
      chk("upd_next_load7", 2'd2, 32'd7, 1'b0);
      wr(2'd0, 32'h0);
      chk("upd_preset7", 2'd1, 32'd7, 1'b0);

      // CTRL write on the same edge as INT
      wr(2'd1, 32'd2);
      wr(2'd0, 32'h9);
      repeat (4) tick();
      chk("sim_in_int", 2'd2, 32'd0, 1'b0);
      wr(2'd0, 32'h9);
      chk("sim_ctrl_wins", 2'd0, 32'h9, 1'b0);
      tick();
      chk("sim_no_pending", 2'd2, 32'd0, 1'b0);
      tick();
      chk("sim_reload2", 2'd2, 32'd2, 1'b0);
      repeat (3) tick();
      chk("sim_rerun_irq", 2'd0, 32'h8, 1'b1);

      tick();
      tick();
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
